// File: rtl/vx_mem_responder_if.sv
// vx_mem_responder_if
//   Request/response bundle for the line-based memory responder.
//   Request side : req_valid/req_ready handshake carrying rw, line address,
//                  byte enables, write data and tag.
//   Response side: rsp_valid/rsp_ready handshake carrying read data and the
//                  tag of the originating read; busy reports reads in flight.
//   master modport: the requester (drives requests, accepts responses).
//   slave modport : the memory responder.
interface vx_mem_responder_if #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int TAG_WIDTH  = 8
);
  logic                   req_valid;
  logic                   req_rw;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_SIZE-1:0]   req_byteen;
  logic [8*DATA_SIZE-1:0] req_data;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   req_ready;
  logic                   rsp_valid;
  logic [8*DATA_SIZE-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]   rsp_tag;
  logic                   rsp_ready;
  logic                   busy;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, busy
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, busy
  );
endinterface

// File: rtl/vx_mem_responder.sv
// vx_mem_responder
//   Line-organised memory with byte-enabled writes and pipelined reads.
//   Reads travel through a LATENCY-deep valid-tagged pipeline into an
//   RSP_DEPTH-entry response FIFO. A credit counter (reads in the pipeline
//   plus FIFO occupancy) throttles read acceptance so the FIFO can never
//   overflow; writes are never throttled and produce no response.
// Ports
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : vx_mem_responder_if.slave (request, response, busy)
module vx_mem_responder #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int TAG_WIDTH  = 8,
  parameter int LATENCY    = 2,
  parameter int RSP_DEPTH  = 4
) (
  input logic                clk,
  input logic                reset,
  vx_mem_responder_if.slave  bus
);

  localparam int LINE_W = 8 * DATA_SIZE;
  localparam int LINES  = 1 << ADDR_WIDTH;
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  // Storage: never reset, contents undefined until written.
  logic [LINE_W-1:0] mem [LINES];

  logic req_fire, wr_fire, rd_fire;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic [LATENCY-1:0]   pipe_vld_q,  pipe_vld_d;
  logic [LINE_W-1:0]    pipe_data_q [LATENCY];
  logic [LINE_W-1:0]    pipe_data_d [LATENCY];
  logic [TAG_WIDTH-1:0] pipe_tag_q  [LATENCY];
  logic [TAG_WIDTH-1:0] pipe_tag_d  [LATENCY];

  logic [LINE_W-1:0]    fifo_data_q [RSP_DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic [CNT_W-1:0]     credit_q, credit_d;

  // Read acceptance depends only on credits and request fields, never on
  // rsp_ready, which keeps the response path out of the request path.
  assign bus.req_ready = !((credit_q == CNT_W'(RSP_DEPTH)) && bus.req_valid && !bus.req_rw);

  assign req_fire = bus.req_valid && bus.req_ready;
  assign wr_fire  = req_fire && bus.req_rw;
  assign rd_fire  = req_fire && !bus.req_rw;

  assign fifo_full  = (count_q == CNT_W'(RSP_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_push  = pipe_vld_q[LATENCY-1];
  assign fifo_pop   = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_data  = fifo_data_q[rd_ptr_q];
  assign bus.rsp_tag   = fifo_tag_q[rd_ptr_q];
  assign bus.busy      = (credit_q != '0);

  // Stage 0 captures the line at the fire edge; a write one cycle earlier
  // has already landed in mem, so the read sees the new data.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_data_d    = pipe_data_q;
    pipe_tag_d     = pipe_tag_q;
    pipe_vld_d[0]  = rd_fire;
    pipe_data_d[0] = mem[bus.req_addr];
    pipe_tag_d[0]  = bus.req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
      pipe_tag_d[i]  = pipe_tag_q[i-1];
    end
  end

  // FIFO pointers wrap naturally: RSP_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = credit_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case ({rd_fire, fifo_pop})
      2'b10:   credit_d = credit_q + CNT_W'(1);
      2'b01:   credit_d = credit_q - CNT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Control state: cleared asynchronously so in-flight reads are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
    end
  end

  // Datapath state: no reset, qualified by the control state above.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < DATA_SIZE; b++) begin
        if (bus.req_byteen[b]) mem[bus.req_addr][8*b +: 8] <= bus.req_data[8*b +: 8];
      end
    end
    pipe_data_q <= pipe_data_d;
    pipe_tag_q  <= pipe_tag_d;
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(fifo_push && fifo_full && !fifo_pop))
    else $error("response FIFO pushed while full");

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    !(fifo_pop && fifo_empty))
    else $error("response FIFO popped while empty");

endmodule

// File: tb/tb_vx_mem_responder.sv
module tb_vx_mem_responder;
  localparam int DS = 64;
  localparam int AW = 8;
  localparam int TW = 8;
  localparam int LW = 8 * DS;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
  } exp_t;

  logic clk;
  logic reset;
  logic rand_rdy;
  logic rdy_force;
  logic rand_bit;
  int   checks;
  int   failures;

  exp_t          exp_q[$];
  logic [LW-1:0] model [256];

  vx_mem_responder_if #(.DATA_SIZE(DS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  vx_mem_responder #(
    .DATA_SIZE(DS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LATENCY(2), .RSP_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rsp_ready = rand_rdy ? rand_bit : rdy_force;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: the FIFO head must always equal the oldest expected response.
  always @(negedge clk) begin
    if (reset && bus.rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got tag=%0h need=no_response", bus.rsp_tag);
      end else begin
        if (bus.rsp_tag !== exp_q[0].tag || bus.rsp_data !== exp_q[0].data) begin
          failures++;
          $display("FAIL rsp_match got tag=%0h data=%0h need tag=%0h data=%0h",
                   bus.rsp_tag, bus.rsp_data, exp_q[0].tag, exp_q[0].data);
        end
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [LW-1:0] fill(input logic [7:0] b);
    logic [LW-1:0] v;
    for (int k = 0; k < DS; k++) v[8*k +: 8] = b;
    return v;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW/32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      failures++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  // Hold the request until it fires; the expected response is recorded at
  // acceptance so it reflects every earlier write.
  task automatic do_req(input logic rw, input logic [AW-1:0] addr, input logic [DS-1:0] be,
                        input logic [LW-1:0] data, input logic [TW-1:0] tag);
    bit   fired;
    exp_t e;
    fired          = 0;
    bus.req_valid  = 1'b1;
    bus.req_rw     = rw;
    bus.req_addr   = addr;
    bus.req_byteen = be;
    bus.req_data   = data;
    bus.req_tag    = tag;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        if (rw) begin
          for (int b = 0; b < DS; b++) if (be[b]) model[addr][8*b +: 8] = data[8*b +: 8];
        end else begin
          e.tag  = tag;
          e.data = model[addr];
          exp_q.push_back(e);
        end
        fired = 1;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!fired) begin
      checks++;
      failures++;
      $display("FAIL req_timeout addr=%0h tag=%0h got=no_fire need=fire", addr, tag);
    end
  endtask

  task automatic offer(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    bus.req_valid  = 1'b1;
    bus.req_rw     = rw;
    bus.req_addr   = addr;
    bus.req_byteen = '1;
    bus.req_data   = fill(8'h77);
    bus.req_tag    = tag;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  int n;

  initial begin
    checks = 0; failures = 0;
    rand_rdy = 1'b0; rdy_force = 1'b1;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0;
    bus.req_byteen = '0; bus.req_data = '0; bus.req_tag = '0;
    for (int a = 0; a < 256; a++) model[a] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_req_ready", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Write-then-read forwarding and read latency
    do_req(1'b1, 8'd5, '1, fill(8'hAA), 8'h00);
    do_req(1'b0, 8'd5, '0, '0, 8'h11);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      @(posedge clk);
      n++;
    end
    check("read_latency", n, 2);
    check("rsp_tag_first", 32'(bus.rsp_tag), 32'h11);
    check("rsp_byte63", 32'(bus.rsp_data[LW-1 -: 8]), 32'hAA);
    @(posedge clk); #1;
    drain(20);

    // Byte-enable merge
    do_req(1'b1, 8'd3, '1, fill(8'h00), 8'h00);
    do_req(1'b1, 8'd3, 64'h1, fill(8'hFF), 8'h00);
    do_req(1'b0, 8'd3, '0, '0, 8'h22);
    for (int i = 0; i < 10 && !bus.rsp_valid; i++) @(negedge clk);
    check("be_byte0", 32'(bus.rsp_data[7:0]), 32'hFF);
    check("be_byte1", 32'(bus.rsp_data[15:8]), 32'h00);
    drain(20);

    // Credit back-pressure, write bypass, in-order drain
    rdy_force = 1'b0;
    for (int t = 0; t < 4; t++) do_req(1'b0, (t % 2) ? 8'd3 : 8'd5, '0, '0, TW'(t));
    repeat (3) @(posedge clk); #1;
    offer(1'b1, 8'd7, 8'h00);
    check("write_ready_when_full", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    do_req(1'b1, 8'd7, '1, fill(8'h5C), 8'h00);
    offer(1'b0, 8'd5, 8'h04);
    check("read_blocked", 32'(bus.req_ready), 0);
    check("busy_full", 32'(bus.busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("read_still_blocked", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    do_req(1'b0, 8'd5, '0, '0, 8'h04);
    do_req(1'b0, 8'd3, '0, '0, 8'h05);
    do_req(1'b0, 8'd7, '0, '0, 8'h06);
    drain(40);

    // Reset with reads in flight
    do_req(1'b0, 8'd5, '0, '0, 8'h31);
    do_req(1'b0, 8'd3, '0, '0, 8'h32);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("midreset_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("postreset_busy", 32'(bus.busy), 0);

    // Random traffic over a defined address window
    for (int a = 0; a < 16; a++) do_req(1'b1, AW'(a), '1, rand_line(), 8'h00);
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else begin
        do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
               DS'({$urandom, $urandom}), rand_line(), TW'($urandom));
      end
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    drain(100);
    repeat (2) @(posedge clk); #1;
    check("final_busy", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running need=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vx_mem_responder.md
VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, line width in bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, line-address width; storage depth is 2^ADDR_WIDTH lines.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, request/response tag width.
REQ-004 SHALL have parameter LATENCY, default 2, range 1..4, read access pipeline depth in cycles.
REQ-005 SHALL have parameter RSP_DEPTH, default 4, power of two >=2, response FIFO depth.
REQ-006 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1, request valid.
REQ-009 SHALL have port req_rw, input, 1, 1=write, 0=read.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH, line address.
REQ-011 SHALL have port req_byteen, input, DATA_SIZE, write byte enables.
REQ-012 SHALL have port req_data, input, 8*DATA_SIZE, write data.
REQ-013 SHALL have port req_tag, input, TAG_WIDTH, request tag.
REQ-014 SHALL have port req_ready, output, 1, request accept.
REQ-015 SHALL have port rsp_valid, output, 1, read response valid.
REQ-016 SHALL have port rsp_data, output, 8*DATA_SIZE, read data.
REQ-017 SHALL have port rsp_tag, output, TAG_WIDTH, tag of the originating read.
REQ-018 SHALL have port rsp_ready, input, 1, response accept.
REQ-019 SHALL have port busy, output, 1, high while any read is in flight or queued.

Function
REQ-020 SHALL accept a request on a cycle where req_valid and req_ready are both high (fire), at most one per cycle.
REQ-021 SHALL, on a write fire, update only the bytes with req_byteen set, at that clock edge; writes produce no response.
REQ-022 SHALL, on a read fire, sample storage after any earlier write, so a read one cycle after a write to the same line returns the new data.
REQ-023 SHALL deliver read data and tag to the response FIFO exactly LATENCY cycles after the fire edge, via a valid-tagged pipeline.
REQ-024 SHALL keep a credit counter of reads in the pipeline plus FIFO occupancy (range 0..RSP_DEPTH); a read fire increments it and a response handshake (rsp_valid and rsp_ready) decrements it; both in one cycle leave it unchanged.
REQ-025 SHALL drive req_ready = 0 when credits == RSP_DEPTH and req_valid and !req_rw; writes are never blocked by credits; req_ready is otherwise 1.
REQ-026 SHALL drive req_ready combinationally from the current credits and the request fields only, with no dependence on rsp_ready, so that no combinational path exists from rsp_ready to req_ready.
REQ-027 SHALL present responses in read-acceptance order; rsp_valid = FIFO not empty; rsp_data and rsp_tag SHALL hold stable while rsp_valid is high and rsp_ready is low.
REQ-028 SHALL let the FIFO accept a push and a pop in the same cycle at any occupancy, including full, with no loss; by REQ-024 overflow SHALL be unreachable.
REQ-029 SHALL wrap the FIFO read and write pointers modulo RSP_DEPTH.
REQ-030 SHALL drive busy = (credits != 0).
REQ-031 SHALL assert (simulation) that the FIFO is never pushed when full and never popped when empty.

Reset
REQ-032 SHALL, while reset is low, clear credits, pipeline valids, and FIFO pointers, and drive rsp_valid = 0 and busy = 0; req_ready follows REQ-025 with credits = 0.
REQ-033 SHALL not reset storage contents, which are undefined until written.
REQ-034 SHALL discard in-flight reads when reset is asserted mid-operation; no stale response SHALL appear after reset is released.

Verification
REQ-035 Write line 5 with all bytes 0xAA, then read line 5 with tag 0x11 in the next cycle, rsp_ready=1 -> rsp_valid exactly 2 cycles after the read fire; rsp_data all 0xAA; rsp_tag 0x11.
REQ-036 Write line 3 with 0x00, then write line 3 with byteen=0x1 and data 0xFF, then read -> byte0=0xFF, other bytes 0x00.
REQ-037 rsp_ready=0, issue back-to-back reads with tags 0..5 -> 4 reads fire; req_ready=0 for read 5; busy=1; raising rsp_ready -> tags 0,1,2,3,4,5 returned in order with no loss.
REQ-038 Credits full with a read pending, and a write on line 7 offered -> write fires; storage updated; credits remain 4.
REQ-039 Drive reset low for 1 cycle with 2 reads in flight -> rsp_valid=0 and busy=0 immediately; no response for either read after release.
REQ-040 Random 10k-cycle traffic with random rsp_ready against a reference model -> all data and tags match; per-cycle order preserved; REQ-031 never fires.
